// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, constants and segment lookup for the seven-segment controller
//
// Contents:
//   conv_state_e  converter FSM states (IDLE, SHIFT, COMMIT)
//   DEC_MAX       largest value that fits in four decimal digits
//   SEG_DASH      pattern shown on every digit when the value overflows
//   SEG_BLANK     all segments off
//   SEG_TABLE     digit 0..9 to active-low segment pattern, bit 6 = a .. bit 0 = g
//   seg_lookup()  table lookup; non-decimal nibbles map to blank
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    localparam logic [15:0] DEC_MAX   = 16'd9999;
    localparam logic [6:0]  SEG_DASH  = 7'b1111110;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    // Entry N holds the pattern for digit N.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0000100,   // 9
        7'b0000000,   // 8
        7'b0001111,   // 7
        7'b0100000,   // 6
        7'b0100100,   // 5
        7'b1001100,   // 4
        7'b0000110,   // 3
        7'b0010010,   // 2
        7'b1001111,   // 1
        7'b0000001    // 0
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
        if (digit > 4'd9) begin
            seg_lookup = SEG_BLANK;
        end else begin
            seg_lookup = SEG_TABLE[digit];
        end
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, 16-bit binary to four BCD digits
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   start_i     begin a conversion of bin_i (acted on only while ready_o is high)
//   bin_i       16-bit unsigned input
//   ready_o     idle and able to take start_i
//   busy_o      conversion in progress (SHIFT or COMMIT)
//   done_o      high for the single COMMIT cycle; bcd_o and ovf_o are valid then
//   bcd_o       four BCD digits, [15:12] = thousands
//   ovf_o       the converted value exceeded 9999
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bcd_o,
    output logic        ovf_o
);

    conv_state_e state_q;
    logic [15:0] bin_q;
    logic [19:0] bcd_q;
    logic [19:0] bcd_adj;
    logic [3:0]  bit_cnt_q;
    logic        ovf_pend_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;

    // Five nibbles are needed so the intermediate value never overflows for inputs up to 65535.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            ovf_pend_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bin_q      <= bin_i;
                        bcd_q      <= '0;
                        bit_cnt_q  <= '0;
                        ovf_pend_q <= (bin_i > DEC_MAX);
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj[18:0], bin_q, 1'b0};
                    bit_cnt_q      <= bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        done_q  <= 1'b1;
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign bcd_o   = bcd_q[15:0];
    assign ovf_o   = ovf_pend_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - bus write port, BCD commit and multiplexed four-digit seven-segment drive
//
// Parameters:
//   SCAN_DIV_W  each digit is lit for 2^SCAN_DIV_W clk cycles
// Build option:
//   SEG_LZB_EN  when defined, leading zeros are blanked (units digit always shown, not while ovf)
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   wr_valid_i   write request, held by the requester until accepted
//   wr_data_i    unsigned 16-bit value to display
//   wr_ready_o   converter idle; write accepted on wr_valid_i && wr_ready_o
//   busy_o       conversion in progress
//   ovf_o        committed value exceeded 9999
//   an_o         active-low anodes, an_o[3] = leftmost (thousands)
//   seg_o        active-low cathodes, bit 6 = a .. bit 0 = g
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV_W = 18
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wr_valid_i,
    input  logic [15:0] wr_data_i,
    output logic        wr_ready_o,
    output logic        busy_o,
    output logic        ovf_o,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o
);

    logic        conv_ready;
    logic        conv_busy;
    logic        conv_done;
    logic        conv_ovf;
    logic [15:0] conv_bcd;

    logic [3:0][3:0]        digit_q;
    logic                   ovf_q;
    logic [SCAN_DIV_W+1:0]  scan_q;
    logic [1:0]             sel;
    logic [3:0]             dig;
    logic                   lead_zero;
    logic [3:0]             an_d;
    logic [3:0]             an_q;
    logic [6:0]             seg_d;
    logic [6:0]             seg_q;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (wr_valid_i && conv_ready),
        .bin_i   (wr_data_i),
        .ready_o (conv_ready),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd),
        .ovf_o   (conv_ovf)
    );

    // Digits and overflow move together on the converter's commit cycle only,
    // so the scan never shows a half-converted value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            digit_q <= '0;
            ovf_q   <= 1'b0;
        end else if (conv_done) begin
            digit_q <= conv_bcd;
            ovf_q   <= conv_ovf;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    // sel 0 is the thousands digit, which lives in digit_q[3].
    assign sel = scan_q[SCAN_DIV_W+1 -: 2];
    assign dig = digit_q[~sel];

    always_comb begin
        lead_zero = 1'b0;
`ifdef SEG_LZB_EN
        case (sel)
            2'd0:    lead_zero = (digit_q[3] == 4'd0);
            2'd1:    lead_zero = (digit_q[3] == 4'd0) && (digit_q[2] == 4'd0);
            2'd2:    lead_zero = (digit_q[3] == 4'd0) && (digit_q[2] == 4'd0) && (digit_q[1] == 4'd0);
            default: lead_zero = 1'b0;
        endcase
`else
        lead_zero = 1'b0;
`endif
    end

    always_comb begin
        an_d = 4'b1111;
        case (sel)
            2'd0:    an_d = 4'b0111;
            2'd1:    an_d = 4'b1011;
            2'd2:    an_d = 4'b1101;
            default: an_d = 4'b1110;
        endcase
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (lead_zero) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_lookup(dig);
        end
    end

    // Anode and cathode registers share one edge so a digit's pattern never leaks into its neighbour.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign wr_ready_o = conv_ready;
    assign busy_o     = conv_busy;
    assign ovf_o      = ovf_q;
    assign an_o       = an_q;
    assign seg_o      = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - scoreboard bench for seg_display_ctrl with SCAN_DIV_W=2
module tb_seg_display_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic [15:0] wr_data_i = '0;
    logic        wr_ready_o;
    logic        busy_o;
    logic        ovf_o;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int sb_q[$];

    seg_display_ctrl #(.SCAN_DIV_W(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .busy_o     (busy_o),
        .ovf_o      (ovf_o),
        .an_o       (an_o),
        .seg_o      (seg_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] tbl_seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    // pos 3 = thousands .. 0 = units
    function automatic logic [6:0] exp_seg(input int v, input int pos);
        int p10;
        p10 = (pos == 0) ? 1 : (pos == 1) ? 10 : (pos == 2) ? 100 : 1000;
        if (v > 9999) return 7'b1111110;
`ifdef SEG_LZB_EN
        if (pos > 0 && v < p10) return 7'b1111111;
`endif
        return tbl_seg((v / p10) % 10);
    endfunction

    function automatic int an_pos(input logic [3:0] an);
        case (an)
            4'b0111: return 3;
            4'b1011: return 2;
            4'b1101: return 1;
            4'b1110: return 0;
            default: return -1;
        endcase
    endfunction

    task automatic write_val(input int v);
        int n;
        n = 0;
        while (!wr_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wr_ready_before_write", wr_ready_o, 1'b1);
        wr_valid_i = 1'b1;
        wr_data_i  = v[15:0];
        @(negedge clk);
        wr_valid_i = 1'b0;
        sb_q.push_back(v);
        chk("busy_after_accept", busy_o, 1'b1);
        chk("ready_low_after_accept", wr_ready_o, 1'b0);
    endtask

    task automatic wait_done(input int exp_busy);
        int n;
        int guard;
        n = 0;
        guard = 0;
        while (!wr_ready_o && guard < 100) begin
            if (busy_o) n++;
            @(negedge clk);
            guard++;
        end
        chk("done_timeout", (guard < 100), 1'b1);
        chk("busy_cycles", n, exp_busy);
        chk("busy_low_when_ready", busy_o, 1'b0);
    endtask

    task automatic check_display();
        int v;
        int pos;
        chk("sb_nonempty", (sb_q.size() > 0), 1'b1);
        if (sb_q.size() > 0) begin
            v = sb_q.pop_front();
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                pos = an_pos(an_o);
                chk("an_onehot", (pos >= 0), 1'b1);
                if (pos >= 0) chk($sformatf("seg_v%0d_p%0d", v, pos), seg_o, exp_seg(v, pos));
            end
            chk($sformatf("ovf_v%0d", v), ovf_o, (v > 9999));
        end
    endtask

    // Called right after rstn is released at a negedge; the scan counter starts from 0.
    task automatic scan_check(input int ncyc, input int v);
        int s;
        int sel;
        logic [3:0] exp_an;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            s = k - 1;
            sel = (s >> 2) & 3;
            exp_an = (sel == 0) ? 4'b0111 : (sel == 1) ? 4'b1011 : (sel == 2) ? 4'b1101 : 4'b1110;
            chk($sformatf("scan_an_k%0d", k), an_o, exp_an);
            chk($sformatf("scan_seg_k%0d", k), seg_o, exp_seg(v, 3 - sel));
        end
        chk("idle_ready", wr_ready_o, 1'b1);
        chk("idle_busy", busy_o, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_an"}, an_o, 4'b1111);
        chk({tag, "_seg"}, seg_o, 7'b1111111);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_ready"}, wr_ready_o, 1'b1);
        chk({tag, "_ovf"}, ovf_o, 1'b0);
    endtask

    initial begin
        int n;
        int acc[3];
        int vals[3];

        // Reset state and scan order, including the counter wrap.
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rstn = 1'b1;
        scan_check(20, 0);

        // Basic conversion with 17 busy cycles.
        write_val(1234);
        wait_done(17);
        check_display();

        // Overflow, then the largest in-range value.
        write_val(10000);
        wait_done(17);
        check_display();
        write_val(9999);
        wait_done(17);
        check_display();

        // Write presented while busy is held off until ready; old value stays visible.
        write_val(42);
        repeat (4) @(negedge clk);
        wr_valid_i = 1'b1;
        wr_data_i  = 16'd55;
        chk("ready_low_at_N5", wr_ready_o, 1'b0);
        n = 0;
        while (!wr_ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("held_write_wait", n, 13);
        @(negedge clk);
        wr_valid_i = 1'b0;
        sb_q.push_back(55);
        chk("held_write_accepted", busy_o, 1'b1);
        check_display();
        wait_done(1);
        check_display();

        // Reset mid-conversion while an overflow is on the display.
        write_val(10000);
        wait_done(17);
        check_display();
        write_val(5678);
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_vals("abort");
        sb_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        scan_check(20, 0);

        // Leading-zero behaviour.
        write_val(7);
        wait_done(17);
        check_display();
        write_val(0);
        wait_done(17);
        check_display();

        // Back-to-back writes with wr_valid held the whole time.
        vals[0] = 111;
        vals[1] = 2222;
        vals[2] = 3;
        wr_valid_i = 1'b1;
        wr_data_i  = vals[0][15:0];
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!wr_ready_o && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_ready_timeout", (n < 60), 1'b1);
            @(negedge clk);
            acc[k] = cyc;
            sb_q.push_back(vals[k]);
            if (k < 2) wr_data_i = vals[k+1][15:0];
            else wr_valid_i = 1'b0;
            if (k > 0) begin
                chk($sformatf("b2b_interval_%0d", k), acc[k] - acc[k-1], 18);
                check_display();
            end
        end
        wait_done(1);
        check_display();
        chk("b2b_sb_drained", sb_q.size(), 0);
        repeat (5) @(negedge clk);
        chk("b2b_no_extra_accept", busy_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Bus-facing controller for the Basys 3 four-digit seven-segment display. It accepts 16-bit binary write transactions from the CPU bus through a ready/valid handshake. It converts each value to BCD with a sequential double-dabble engine and commits the four digits atomically. It then time-multiplexes the common-cathode segments across the four active-low anodes at a prescaled refresh rate.

## Interface
- SCAN_DIV_W, 18, prescaler width; each digit is lit for 2^SCAN_DIV_W clk cycles (2.62 ms at 100 MHz)
- clk  in  1  100 MHz clock
- rstn  in  1  reset, asynchronous, active-low
- wr_valid  in  1  write request
- wr_data  in  16  unsigned binary value to display
- wr_ready  out  1  high when the converter is idle; write accepted on wr_valid && wr_ready
- busy  out  1  conversion in progress
- ovf  out  1  committed value exceeded 9999
- an  out  4  anodes, active-low; an[3] is the leftmost digit
- seg  out  7  cathodes [0:6] = a..g, active-low

## Operation
- Converter FSM has three states:
  - IDLE: wr_ready=1. On accept, latch wr_data into the shift register, clear the 20-bit BCD scratch, set bit_cnt=0 and set ovf_pend = (wr_data > 9999). Go to SHIFT.
  - SHIFT: 16 iterations. Each iteration adds 3 to every BCD nibble ≥5, then shifts {bcd, bin} left by 1. At bit_cnt==15 go to COMMIT.
  - COMMIT: copy BCD nibbles [15:0] into digit_q[3:0] and ovf_pend into ovf in one cycle. Go to IDLE.
- Writes presented while wr_ready=0 are not accepted. The requester holds wr_valid until accepted. Nothing is queued.
- Scan counter has width SCAN_DIV_W+2, is free-running and wraps. Its top 2 bits select the digit: 00→an=0111 (thousands), 01→1011, 10→1101, 11→1110 (units).
- Segment codes, 0–9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- If ovf=1, every digit shows dash 1111110.
- digit_q changes only in COMMIT, so a torn value is never displayed.

## Timing
- Reset values:
  - an=1111, seg=1111111
  - digit_q=0, ovf=0, busy=0, wr_ready=1
  - scan counter 0, FSM IDLE
- Conversion latency: accept at edge N, SHIFT for edges N+1..N+16, COMMIT at edge N+17. New digits appear on an/seg at edge N+18 when the corresponding digit slot is active.
- wr_ready is low and busy is high from N+1 through N+17. A new write can be accepted at edge N+18.
- an/seg are registered one cycle after the scan-select change. Both update on the same edge, so there is no ghosting skew.
- rstn assertion mid-conversion aborts immediately. The partial result is discarded and the display blanks.
- Scan counter wrap from all-ones to 0 returns the display to the thousands digit without an extra cycle.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking.
  - Digits left of the first nonzero digit show 1111111.
  - The units digit is always shown, so value 0 displays "   0".
  - Blanking does not apply while ovf=1.
- SEG_LZB_EN undefined: all four digits are always shown, e.g. 7 displays "0007".

## Structure
- Package seg_pkg holds:
  - the state enum (IDLE, SHIFT, COMMIT)
  - SEG_DASH and SEG_BLANK constants
  - the 10-entry digit-to-segment constant table and lookup function
  - the DEC_MAX=9999 constant
- Sub-module bin2bcd_seq holds the double-dabble FSM and exposes start, ready and done with 16-bit in and 16-bit BCD out plus ovf. The top level holds the handshake, the digit register and the scan mux.

## Test plan
Benches use SCAN_DIV_W=2.
- Write 1234 → busy for 17 cycles, ready at N+18. Scan shows an=0111/seg=1001111, 1011/0010010, 1101/0000110, 1110/1001100, repeating every 16 cycles.
- Write 10000 → ovf=1 and all four digits show 1111110. Then write 9999 → ovf=0 and every digit shows 0000100.
- Write 42, then assert wr_valid with 55 at N+5 → not accepted while wr_ready=0. It is accepted at N+18, and the display shows 42 between those points.
- Assert rstn low at N+8 mid-conversion of 5678 → outputs return to reset values immediately. After release, the FSM is IDLE and the display shows 0.
- With SEG_LZB_EN, write 7 → blank, blank, blank, 0001111. Write 0 → blank ×3, 0000001. Without the macro, 7 shows 0000001 ×3, then 0001111.
- Back-to-back writes with wr_valid held continuously → one accept every 18 cycles, with no missed or duplicated commits.
